// File: rtl/fpga_led_switch_pkg.sv
// Shared constants for the switch-to-LED block.
// Group geometry and default timing parameters.
package fpga_led_switch_pkg;

  localparam int N_GROUPS = 4;
  localparam int GROUP_W  = 4;
  localparam int LED_W    = N_GROUPS * GROUP_W;

  localparam int DEF_DEBOUNCE_CYCLES = 16;
  localparam int DEF_SYNC_STAGES     = 2;

endpackage

// File: rtl/led_btn_debounce.sv
// One-bit debouncer: output follows input only after it has
// disagreed for DEBOUNCE_CYCLES consecutive cycles.
module led_btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  if (DEBOUNCE_CYCLES == 0) begin : g_bypass

    assign dout = din;

  end else begin : g_filter

    localparam int CW =
      (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          state;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
      if (rst) begin
        state <= 1'b0;
        cnt   <= '0;
      end else if (din == state) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        state <= din;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end

    assign dout = state;

  end

endmodule

// File: rtl/fpga_led_switch.sv
// Synchronizes switches and buttons, debounces buttons and
// drives registered LEDs with per-group blanking.
module fpga_led_switch
  import fpga_led_switch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [LED_W-1:0]    sw,
  input  logic [N_GROUPS-1:0] btn,
  output logic [LED_W-1:0]    led
);

  logic [LED_W-1:0]    sw_q  [SYNC_STAGES];
  logic [N_GROUPS-1:0] btn_q [SYNC_STAGES];
  logic [LED_W-1:0]    sw_s;
  logic [N_GROUPS-1:0] btn_s;
  logic [N_GROUPS-1:0] btn_db;
  logic [LED_W-1:0]    led_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sw_q[i]  <= '0;
        btn_q[i] <= '0;
      end
    end else begin
      sw_q[0]  <= sw;
      btn_q[0] <= btn;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sw_q[i]  <= sw_q[i-1];
        btn_q[i] <= btn_q[i-1];
      end
    end
  end

  assign sw_s  = sw_q[SYNC_STAGES-1];
  assign btn_s = btn_q[SYNC_STAGES-1];

  for (genvar g = 0; g < N_GROUPS; g++) begin : g_db
    led_btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk  (clk),
      .rst  (rst),
      .din  (btn_s[g]),
      .dout (btn_db[g])
    );
  end

  always_comb begin
    led_next = sw_s;
    for (int g = 0; g < N_GROUPS; g++) begin
      if (btn_db[g]) led_next[g*GROUP_W +: GROUP_W] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) led <= '0;
    else     led <= led_next;
  end

endmodule

// File: tb/tb_fpga_led_switch.sv
// Randomized and directed scoreboard bench for fpga_led_switch
// (DEBOUNCE_CYCLES = 4, SYNC_STAGES = 2).
module tb_fpga_led_switch;

  localparam int DB  = 4;
  localparam int OFF = 8;
  localparam int MAXC = 4096;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] sw;
  logic [3:0]  btn;
  logic [15:0] led;

  fpga_led_switch #(
    .DEBOUNCE_CYCLES(DB),
    .SYNC_STAGES(2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .sw  (sw),
    .btn (btn),
    .led (led)
  );

  always #5 clk = ~clk;

  logic [15:0] sw_h  [MAXC];
  logic [3:0]  btn_h [MAXC];
  logic        rst_h [MAXC];
  logic [3:0]  db_h  [MAXC];
  logic [15:0] expq  [$];
  int          k = OFF;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;

  // Value seen after edge m at the end of a 2-flop synchronizer.
  function automatic logic [15:0] syn_sw(int m);
    return (rst_h[m] || rst_h[m-1]) ? 16'h0 : sw_h[m-1];
  endfunction

  function automatic logic [3:0] syn_btn(int m);
    return (rst_h[m] || rst_h[m-1]) ? 4'h0 : btn_h[m-1];
  endfunction

  task automatic step(input logic r, input logic [15:0] s,
                      input logic [3:0] b);
    logic [15:0] e;
    logic [3:0]  sb;
    logic        prev, all_diff;
    rst = r; sw = s; btn = b;
    k++;
    rst_h[k] = r; sw_h[k] = s; btn_h[k] = b;
    if (r) begin
      db_h[k] = 4'h0;
      e = 16'h0;
    end else begin
      for (int g = 0; g < 4; g++) begin
        prev = db_h[k-1][g];
        all_diff = 1'b1;
        for (int j = 0; j < DB; j++) begin
          sb = syn_btn(k-1-j);
          if (sb[g] == prev) all_diff = 1'b0;
        end
        db_h[k][g] = all_diff ? ~prev : prev;
      end
      e = syn_sw(k-1);
      for (int g = 0; g < 4; g++)
        if (db_h[k-1][g]) e[g*4 +: 4] = 4'h0;
    end
    expq.push_back(e);
    @(negedge clk);
  endtask

  task automatic hold(input logic r, input logic [15:0] s,
                      input logic [3:0] b, input int n);
    for (int i = 0; i < n; i++) step(r, s, b);
  endtask

  // Monitor: led is presented every cycle; compare each one.
  initial begin
    logic [15:0] e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        n_cmp++;
        if (led !== e) begin
          n_bad++;
          $display("FAIL led cyc=%0d got=%h exp=%h", cyc, led, e);
        end
      end
    end
  end

  initial begin
    logic [15:0] s;
    logic [3:0]  b;
    for (int i = 0; i < MAXC; i++) begin
      sw_h[i] = '0; btn_h[i] = '0; rst_h[i] = 1'b1; db_h[i] = '0;
    end
    rst = 1'b1; sw = 16'hFFFF; btn = 4'h0;

    hold(1, 16'hFFFF, 4'b0000, 2);
    hold(0, 16'hFFFF, 4'b0000, 5);
    hold(0, 16'hFFFF, 4'b0001, 10);
    hold(0, 16'hFFFF, 4'b0010, 10);
    hold(0, 16'hFFFF, 4'b0100, 10);
    hold(0, 16'hFFFF, 4'b1000, 10);
    hold(0, 16'hFFFF, 4'b0101, 10);
    hold(0, 16'hFFFF, 4'b1101, 10);
    hold(0, 16'hFFFF, 4'b1111, 10);
    hold(0, 16'hFFFF, 4'b0000, 10);
    hold(0, 16'hA5A5, 4'b0000, 5);
    hold(0, 16'h0F0F, 4'b0000, 5);
    hold(0, 16'hC3C3, 4'b0000, 5);
    hold(0, 16'hF0F0, 4'b0010, 10);
    hold(0, 16'hAAAA, 4'b1000, 10);
    hold(0, 16'hAAAA, 4'b0000, 10);
    hold(0, 16'h1234, 4'b0001, 2);
    hold(0, 16'h1234, 4'b0000, 8);
    hold(0, 16'h5678, 4'b0001, 3);
    hold(1, 16'h5678, 4'b0001, 2);
    hold(0, 16'h5678, 4'b0001, 10);
    hold(0, 16'h9ABC, 4'b1111, 3);
    hold(0, 16'h9ABC, 4'b0000, 10);

    s = 16'h0; b = 4'h0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) s = 16'($urandom);
      for (int g = 0; g < 4; g++)
        if ($urandom_range(0, 5) == 0) b[g] = ~b[g];
      if ($urandom_range(0, 199) == 0)
        hold(1, s, b, $urandom_range(1, 3));
      else
        step(0, s, b);
    end
    hold(0, s, 4'h0, 10);

    @(posedge clk);
    #2;
    if (expq.size() != 0) begin
      n_bad++;
      $display("FAIL drain left=%0d exp=0", expq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
